// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider. Each channel runs a period/high-time
// counter and accepts new settings through a shared valid/ready port, applied at the next wrap.
module clock_div_prog #(
  parameter int CNT_W      = 27,
  parameter int NCH        = 2,
  parameter int CH_W       = 1,
  parameter int DEF_PERIOD = 100000000,
  parameter int DEF_HIGH   = 50000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [NCH-1:0]   enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'((DEF_PERIOD < 2) ? 2 : DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  // A period below 2 would leave no room for a wrap, so it is raised to 2.
  function automatic logic [CNT_W-1:0] coerce_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] prd      [NCH];
  logic [CNT_W-1:0] hi       [NCH];
  logic [CNT_W-1:0] shadow_p [NCH];
  logic [CNT_W-1:0] shadow_h [NCH];
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   running;
  logic [NCH-1:0]   hit;

  // Out-of-range channel indices are always ready and never hit a channel.
  always_comb begin
    cfg_ready = 1'b1;
    hit       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~pending[i];
        hit[i]    = cfg_valid & ~pending[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]      <= '0;
        prd[i]      <= DEF_P;
        hi[i]       <= DEF_H;
        shadow_p[i] <= DEF_P;
        shadow_h[i] <= DEF_H;
      end
      pending <= '0;
      running <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!enable[i]) begin
          running[i] <= 1'b0;
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pending[i]) begin
            prd[i]     <= coerce_period(shadow_p[i]);
            hi[i]      <= shadow_h[i];
            pending[i] <= 1'b0;
          end
        end else if (!running[i]) begin
          // first enabled edge restarts the period at count 0
          running[i] <= 1'b1;
          cnt[i]     <= '0;
          tick[i]    <= 1'b1;
          clk_out[i] <= (hi[i] != '0);
        end else if (cnt[i] >= prd[i] - 1'b1) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          if (pending[i]) begin
            prd[i]     <= coerce_period(shadow_p[i]);
            hi[i]      <= shadow_h[i];
            pending[i] <= 1'b0;
            clk_out[i] <= (shadow_h[i] != '0);
          end else begin
            clk_out[i] <= (hi[i] != '0);
          end
        end else begin
          cnt[i]     <= cnt[i] + 1'b1;
          tick[i]    <= 1'b0;
          clk_out[i] <= ((cnt[i] + 1'b1) < hi[i]);
        end
        // a hit only happens when pending is clear, so it never races an apply
        if (hit[i]) begin
          shadow_p[i] <= cfg_period;
          shadow_h[i] <= cfg_high;
          pending[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed scenarios plus random traffic, checked each
// cycle against a phase-based model of the divider rules.
module tb_clock_div_prog;

  localparam int CNT_W = 8;
  localparam int NCH   = 2;
  localparam int CH_W  = 2;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic [NCH-1:0]   enable = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  clock_div_prog #(
    .CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W), .DEF_PERIOD(10), .DEF_HIGH(5)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel is described by its phase within the current period.
  int m_ph [NCH];
  int m_p  [NCH];
  int m_h  [NCH];
  int m_sp [NCH];
  int m_sh [NCH];
  bit m_pend [NCH];
  bit m_run  [NCH];

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = 0; m_p[i] = 10; m_h[i] = 5; m_sp[i] = 10; m_sh[i] = 5;
      m_pend[i] = 0; m_run[i] = 0;
    end
  endfunction

  function automatic bit model_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  function automatic void model_apply(input int i);
    m_p[i] = (m_sp[i] < 2) ? 2 : m_sp[i];
    m_h[i] = m_sh[i];
    m_pend[i] = 0;
  endfunction

  task automatic cycle();
    bit xfer;
    int xch;
    #1;
    check("cfg_ready", int'(cfg_ready), int'(model_ready()));
    xfer = cfg_valid && model_ready();
    xch  = int'(cfg_ch);
    @(posedge clk_in);
    for (int i = 0; i < NCH; i++) begin
      if (!enable[i]) begin
        m_run[i] = 0; m_ph[i] = 0;
        if (m_pend[i]) model_apply(i);
      end else if (!m_run[i]) begin
        m_run[i] = 1; m_ph[i] = 0;
      end else if (m_ph[i] == m_p[i] - 1) begin
        m_ph[i] = 0;
        if (m_pend[i]) model_apply(i);
      end else begin
        m_ph[i]++;
      end
    end
    if (xfer && xch < NCH) begin
      m_sp[xch] = int'(cfg_period); m_sh[xch] = int'(cfg_high); m_pend[xch] = 1;
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("clk_out[%0d]", i), int'(clk_out[i]), int'(enable[i] && m_ph[i] < m_h[i]));
      check($sformatf("tick[%0d]", i), int'(tick[i]), int'(enable[i] && m_ph[i] == 0));
    end
  endtask

  task automatic write(input int ch, input int p, input int h);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pre_wrap(input int ch);
    for (int k = 0; k < 300 && m_ph[ch] != m_p[ch] - 1; k++) cycle();
    check("pre_wrap_timeout", int'(m_ph[ch] == m_p[ch] - 1), 1);
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    enable = 2'b01;

    // default 10-cycle period on ch0, ch1 idle
    repeat (30) cycle();

    // mid-period rewrite, then a second write stalled while pending
    repeat (3) cycle();
    write(0, 4, 1);
    write(0, 6, 2);
    repeat (20) cycle();

    // write landing exactly on the wrap edge
    wait_pre_wrap(0);
    write(0, 10, 5);
    repeat (25) cycle();

    // degenerate settings
    write(0, 0, 0);
    repeat (14) cycle();
    write(0, 3, 7);
    repeat (14) cycle();

    // out-of-range channel
    cfg_ch = 2'd3;
    #1;
    check("ready_ch3", int'(cfg_ready), 1);
    write(3, 5, 1);
    repeat (8) cycle();

    // enable ch1, disable ch0 with an update pending
    enable = 2'b11;
    repeat (5) cycle();
    write(0, 7, 3);
    enable = 2'b10;
    repeat (3) cycle();
    enable = 2'b11;
    repeat (16) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) enable = NCH'($urandom_range(0, 3));
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = CH_W'($urandom_range(0, 3));
      cfg_period = CNT_W'($urandom_range(0, 12));
      cfg_high   = CNT_W'($urandom_range(0, 13));
      cycle();
    end
    cfg_valid = 1'b0;

    // asynchronous reset mid-period with an update pending
    enable = 2'b11;
    repeat (12) cycle();
    write(0, 4, 2);
    repeat (2) cycle();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    cfg_ch = '0;
    check("async_clk_out", int'(clk_out), 0);
    check("async_tick", int'(tick), 0);
    #1;
    check("async_ready", int'(cfg_ready), 1);
    @(posedge clk_in);
    #1;
    check("hold_clk_out", int'(clk_out), 0);
    reset = 1'b0;
    repeat (25) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
